// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port main-memory arbiter.
package mem_arb_pkg;

  // Sequencer states for one memory transaction.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  // Polarity of the memory read_write line.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Grant index values.
  localparam logic GRANT_M0 = 1'b0;
  localparam logic GRANT_M1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way request picker with a last-grant pointer.
// A lone request wins outright; a tie goes to the requester not granted last,
// or always to requester 0 when fixed_priority is set.
module rr_arbiter2
  import mem_arb_pkg::*;
#(
  parameter int fixed_priority = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       grant_upd_i,
  output logic       valid_o,
  output logic       grant_o
);

  logic last_q;
  logic last_d;

  // Combinational pick from the current request pair.
  always_comb begin
    valid_o = |req_i;
    if (req_i == 2'b11) begin
      grant_o = (fixed_priority != 0) ? GRANT_M0 : ~last_q;
    end else if (req_i[1]) begin
      grant_o = GRANT_M1;
    end else begin
      grant_o = GRANT_M0;
    end
  end

  // Pointer follows the completed grant only when the sequencer says so.
  always_comb begin
    last_d = update_i ? grant_upd_i : last_q;
  end

  // Pointer starts at requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= GRANT_M1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and sequencer sharing one single-port memory between an
// instruction-fetch port (m0) and a load/store port (m1).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int address_size   = 16,
  parameter int data_width     = 16,
  parameter int fixed_priority = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m0_req,
  input  logic                    m0_rw,
  input  logic [address_size-1:0] m0_addr,
  input  logic [data_width-1:0]   m0_wdata,
  output logic [data_width-1:0]   m0_rdata,
  output logic                    m0_ack,
  input  logic                    m1_req,
  input  logic                    m1_rw,
  input  logic [address_size-1:0] m1_addr,
  input  logic [data_width-1:0]   m1_wdata,
  output logic [data_width-1:0]   m1_rdata,
  output logic                    m1_ack,
  output logic [address_size-1:0] mem_address,
  output logic                    mem_read_write,
  output logic                    mem_enable,
  inout  wire  [data_width-1:0]   mem_data
);

  state_e                  state_q;
  logic                    grant_q;
  logic                    rw_q;
  logic [address_size-1:0] addr_q;
  logic [data_width-1:0]   wdata_q;
  logic                    drive_q;
  logic                    en_q;
  logic                    mrw_q;
  logic [1:0]              ack_q;
  logic [data_width-1:0]   rdata0_q;
  logic [data_width-1:0]   rdata1_q;

  logic                    arb_valid;
  logic                    arb_grant;
  logic                    sel_rw;
  logic [address_size-1:0] sel_addr;
  logic [data_width-1:0]   sel_wdata;

  rr_arbiter2 #(
    .fixed_priority(fixed_priority)
  ) u_pick (
    .clk        (clk),
    .reset      (reset),
    .req_i      ({m1_req, m0_req}),
    .update_i   (state_q == ST_RESP),
    .grant_upd_i(grant_q),
    .valid_o    (arb_valid),
    .grant_o    (arb_grant)
  );

  // Route the winning requester's fields toward the latch.
  always_comb begin
    sel_rw    = m0_rw;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (arb_grant == GRANT_M1) begin
      sel_rw    = m1_rw;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  // Transaction sequencer; every memory-side and requester-side output is a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= GRANT_M0;
      rw_q     <= RW_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      drive_q  <= 1'b0;
      en_q     <= 1'b0;
      mrw_q    <= RW_READ;
      ack_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack_q <= 2'b00;
      unique case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_q <= arb_grant;
            rw_q    <= sel_rw;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            en_q    <= 1'b1;
            mrw_q   <= sel_rw;
            drive_q <= (sel_rw == RW_WRITE);
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          drive_q <= 1'b0;
          if (rw_q == RW_READ) begin
            state_q <= ST_CAPTURE;
          end else begin
            // The memory takes the write at the edge closing this cycle.
            en_q           <= 1'b0;
            mrw_q          <= RW_READ;
            ack_q[grant_q] <= 1'b1;
            state_q        <= ST_RESP;
          end
        end
        ST_CAPTURE: begin
          if (grant_q == GRANT_M0) begin
            rdata0_q <= mem_data;
          end else begin
            rdata1_q <= mem_data;
          end
          en_q           <= 1'b0;
          mrw_q          <= RW_READ;
          ack_q[grant_q] <= 1'b1;
          state_q        <= ST_RESP;
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Address holds after a transaction, so the latched address feeds the pins directly.
  assign mem_address    = addr_q;
  assign mem_read_write = mrw_q;
  assign mem_enable     = en_q;
  assign mem_data       = drive_q ? wdata_q : {data_width{1'bz}};
  assign m0_ack         = ack_q[0];
  assign m1_ack         = ack_q[1];
  assign m0_rdata       = rdata0_q;
  assign m1_rdata       = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin instance and a fixed-priority instance,
// each with its own memory, checked cycle by cycle against a transaction-level model.
module tb_mem_arbiter;

  typedef struct {
    bit          rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          gap;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_s = 1'b1;
  logic        req_s  [4];
  logic        rw_s   [4];
  logic [15:0] addr_s [4];
  logic [15:0] wd_s   [4];
  logic [15:0] rd_s   [4];
  logic        ack_s  [4];
  logic [15:0] maddr  [2];
  logic        mrw    [2];
  logic        men    [2];
  tri1  [15:0] mdata0;
  tri1  [15:0] mdata1;
  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];
  bit          minit;

  mem_arbiter #(.address_size(16), .data_width(16), .fixed_priority(0)) u_rr (
    .clk(clk), .reset(reset_s),
    .m0_req(req_s[0]), .m0_rw(rw_s[0]), .m0_addr(addr_s[0]), .m0_wdata(wd_s[0]),
    .m0_rdata(rd_s[0]), .m0_ack(ack_s[0]),
    .m1_req(req_s[1]), .m1_rw(rw_s[1]), .m1_addr(addr_s[1]), .m1_wdata(wd_s[1]),
    .m1_rdata(rd_s[1]), .m1_ack(ack_s[1]),
    .mem_address(maddr[0]), .mem_read_write(mrw[0]), .mem_enable(men[0]), .mem_data(mdata0)
  );

  mem_arbiter #(.address_size(16), .data_width(16), .fixed_priority(1)) u_fp (
    .clk(clk), .reset(reset_s),
    .m0_req(req_s[2]), .m0_rw(rw_s[2]), .m0_addr(addr_s[2]), .m0_wdata(wd_s[2]),
    .m0_rdata(rd_s[2]), .m0_ack(ack_s[2]),
    .m1_req(req_s[3]), .m1_rw(rw_s[3]), .m1_addr(addr_s[3]), .m1_wdata(wd_s[3]),
    .m1_rdata(rd_s[3]), .m1_ack(ack_s[3]),
    .mem_address(maddr[1]), .mem_read_write(mrw[1]), .mem_enable(men[1]), .mem_data(mdata1)
  );

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 32'h1111);
  endfunction

  // Memories: asynchronous read onto the bus while enabled for read, write on the clock edge.
  assign mdata0 = (men[0] && mrw[0]) ? mem0[maddr[0][7:0]] : 16'hzzzz;
  assign mdata1 = (men[1] && mrw[1]) ? mem1[maddr[1][7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!minit) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= init_val(i);
        mem1[i] <= init_val(i);
      end
      minit <= 1'b1;
    end else begin
      if (men[0] && !mrw[0]) mem0[maddr[0][7:0]] <= mdata0;
      if (men[1] && !mrw[1]) mem1[maddr[1][7:0]] <= mdata1;
    end
  end

  // Requester queues (index = instance*2 + port) and reference model state.
  op_t         q [4][$];
  bit          mact  [2];
  int          ms    [2];
  int          mack  [2];
  int          nsamp [2];
  bit          mw    [2];
  bit          last  [2];
  op_t         mop   [2];
  logic [15:0] exp_rd   [2][2];
  logic [15:0] exp_addr [2];
  logic [15:0] sh [2][256];
  int          alog [2][$];
  bit          glitch;
  bit          rst_req;
  int          cyc = -1;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Compare one instance's outputs for the current cycle with the model.
  task automatic check_inst(input int k);
    bit          en_e;
    bit          ack_now;
    logic [15:0] bus;
    string       pfx;
    pfx     = (k == 0) ? "rr" : "fp";
    en_e    = mact[k] && (cyc > ms[k]) && (cyc < mack[k]);
    ack_now = mact[k] && (cyc == mack[k]);
    if (ack_now) begin
      if (mop[k].rw) exp_rd[k][mw[k]] = sh[k][mop[k].addr[7:0]];
      else sh[k][mop[k].addr[7:0]] = mop[k].wdata;
      $display("txn %s m%0d %s addr=%h data=%h cycle=%0d", pfx, mw[k],
               mop[k].rw ? "read " : "write", mop[k].addr,
               mop[k].rw ? exp_rd[k][mw[k]] : mop[k].wdata, cyc);
    end
    chk({pfx, "_mem_enable"}, 32'(men[k]), 32'(en_e));
    chk({pfx, "_mem_read_write"}, 32'(mrw[k]), 32'(en_e ? mop[k].rw : 1'b1));
    chk({pfx, "_mem_address"}, 32'(maddr[k]), 32'(exp_addr[k]));
    chk({pfx, "_m0_ack"}, 32'(ack_s[k*2]), 32'(ack_now && (mw[k] == 1'b0)));
    chk({pfx, "_m1_ack"}, 32'(ack_s[k*2+1]), 32'(ack_now && (mw[k] == 1'b1)));
    chk({pfx, "_m0_rdata"}, 32'(rd_s[k*2]), 32'(exp_rd[k][0]));
    chk({pfx, "_m1_rdata"}, 32'(rd_s[k*2+1]), 32'(exp_rd[k][1]));
    bus = (k == 0) ? mdata0 : mdata1;
    if (!en_e) chk({pfx, "_bus_hiz"}, 32'(bus), 32'h0000ffff);
    else if (cyc == ms[k] + 1 && !mop[k].rw) chk({pfx, "_bus_wdata"}, 32'(bus), 32'(mop[k].wdata));
    if (ack_s[k*2]) alog[k].push_back(0);
    if (ack_s[k*2+1]) alog[k].push_back(1);
    if (ack_now) begin
      if (q[k*2+mw[k]].size() > 0) void'(q[k*2+mw[k]].pop_front());
      mact[k]  = 1'b0;
      last[k]  = mw[k];
      nsamp[k] = cyc + 1;
    end
  endtask

  // Present each requester's head operation (after its idle gap) for this cycle.
  task automatic drive_inst(input int k);
    op_t h;
    for (int j = 0; j < 2; j++) begin
      int idx;
      idx = k * 2 + j;
      if (glitch && j == 0 && mact[k]) begin
        req_s[idx]  = 1'($urandom);
        rw_s[idx]   = 1'($urandom);
        addr_s[idx] = 16'($urandom);
        wd_s[idx]   = 16'($urandom);
      end else if (q[idx].size() > 0) begin
        h = q[idx][0];
        if (h.gap > 0) begin
          h.gap--;
          q[idx][0] = h;
          req_s[idx] = 1'b0;
        end else begin
          req_s[idx]  = 1'b1;
          rw_s[idx]   = h.rw;
          addr_s[idx] = h.addr;
          wd_s[idx]   = h.wdata;
        end
      end else begin
        req_s[idx] = 1'b0;
      end
    end
  endtask

  // Advance the model with this cycle's inputs: reset, or arbitration in an idle sampling cycle.
  task automatic advance_inst(input int k);
    bit r0;
    bit r1;
    bit w;
    if (reset_s) begin
      mact[k]     = 1'b0;
      nsamp[k]    = cyc + 1;
      last[k]     = 1'b1;
      exp_rd[k][0] = 16'h0;
      exp_rd[k][1] = 16'h0;
      exp_addr[k] = 16'h0;
    end else if (!mact[k] && cyc == nsamp[k]) begin
      r0 = req_s[k*2];
      r1 = req_s[k*2+1];
      if (r0 || r1) begin
        if (r0 && r1) w = (k == 1) ? 1'b0 : !last[k];
        else w = r1;
        mop[k].rw    = rw_s[k*2+w];
        mop[k].addr  = addr_s[k*2+w];
        mop[k].wdata = wd_s[k*2+w];
        mop[k].gap   = 0;
        mw[k]        = w;
        mact[k]      = 1'b1;
        ms[k]        = cyc;
        mack[k]      = cyc + (mop[k].rw ? 3 : 2);
        exp_addr[k]  = mop[k].addr;
      end else begin
        nsamp[k] = cyc + 1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check_inst(0);
    check_inst(1);
    reset_s = rst_req;
    drive_inst(0);
    drive_inst(1);
    advance_inst(0);
    advance_inst(1);
  endtask

  task automatic push_op(input int idx, input bit rw, input logic [15:0] addr,
                         input logic [15:0] wdata, input int gap);
    op_t o;
    o.rw = rw; o.addr = addr; o.wdata = wdata; o.gap = gap;
    q[idx].push_back(o);
  endtask

  task automatic run_until_idle(input int max_cycles, input string tag);
    int n;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() != 0 || mact[0] || mact[1])
           && n < max_cycles) begin
      step();
      n++;
    end
    checks++;
    assert (n < max_cycles) else begin
      failures++;
      $error("FAIL %s_timeout: observed=%0d cycles expected below %0d", tag, n, max_cycles);
    end
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 4; i++) begin
      req_s[i] = 1'b0; rw_s[i] = 1'b1; addr_s[i] = 16'h0; wd_s[i] = 16'h0;
    end
    for (int k = 0; k < 2; k++) begin
      mact[k] = 1'b0; ms[k] = 0; mack[k] = 0; nsamp[k] = 0; mw[k] = 1'b0; last[k] = 1'b1;
      mop[k].rw = 1'b1; mop[k].addr = 16'h0; mop[k].wdata = 16'h0; mop[k].gap = 0;
      exp_rd[k][0] = 16'h0; exp_rd[k][1] = 16'h0; exp_addr[k] = 16'h0;
      for (int i = 0; i < 256; i++) sh[k][i] = init_val(i);
    end
    glitch  = 1'b0;
    rst_req = 1'b1;

    // Reset held with both requesters asking; m0 must win the first tie afterwards.
    push_op(0, 1'b1, 16'h0030, 16'h0, 0); push_op(1, 1'b1, 16'h0031, 16'h0, 0);
    push_op(2, 1'b1, 16'h0030, 16'h0, 0); push_op(3, 1'b1, 16'h0031, 16'h0, 0);
    repeat (3) step();
    rst_req = 1'b0;

    // Reset lands in the CAPTURE cycle of m0's read.
    guard = 0;
    while (!(mact[0] && (cyc + 1 == ms[0] + 2)) && guard < 20) begin
      step();
      guard++;
    end
    chk("first_grant_m0", 32'(mw[0]), 32'd0);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    q[0].delete(); q[2].delete();
    step();
    chk("rst_capture_m0_ack", 32'(ack_s[0]), 32'd0);
    chk("rst_capture_mem_enable", 32'(men[0]), 32'd0);
    chk("rst_capture_m0_rdata", 32'(rd_s[0]), 32'd0);
    run_until_idle(50, "after_reset");

    // Continuous contention for preloaded words 1 and 2.
    alog[0].delete(); alog[1].delete();
    for (int i = 0; i < 4; i++) begin
      push_op(0, 1'b1, 16'h0001, 16'h0, 0); push_op(1, 1'b1, 16'h0002, 16'h0, 0);
      push_op(2, 1'b1, 16'h0001, 16'h0, 0); push_op(3, 1'b1, 16'h0002, 16'h0, 0);
    end
    run_until_idle(200, "contention");
    chk("rr_ack_count", 32'(alog[0].size()), 32'd8);
    chk("fp_ack_count", 32'(alog[1].size()), 32'd8);
    for (int i = 0; i < 8 && i < alog[0].size() && i < alog[1].size(); i++) begin
      chk($sformatf("rr_ack_order_%0d", i), 32'(alog[0][i]), 32'(i % 2));
      chk($sformatf("fp_ack_order_%0d", i), 32'(alog[1][i]), 32'(i / 4));
    end
    chk("rr_m0_rdata_1111", 32'(rd_s[0]), 32'h1111);
    chk("rr_m1_rdata_2222", 32'(rd_s[1]), 32'h2222);
    chk("fp_m1_rdata_2222", 32'(rd_s[3]), 32'h2222);

    // m0 write then read back of the same word.
    push_op(0, 1'b0, 16'h0010, 16'hBEEF, 0); push_op(0, 1'b1, 16'h0010, 16'h0, 0);
    push_op(2, 1'b0, 16'h0010, 16'hBEEF, 0); push_op(2, 1'b1, 16'h0010, 16'h0, 0);
    run_until_idle(50, "beef");
    chk("rr_m0_rdata_beef", 32'(rd_s[0]), 32'hBEEF);
    chk("fp_m0_rdata_beef", 32'(rd_s[2]), 32'hBEEF);

    // m1 write while m0_req and its fields toggle mid-transaction.
    alog[0].delete(); alog[1].delete();
    glitch = 1'b1;
    push_op(1, 1'b0, 16'h0020, 16'h5A5A, 0);
    push_op(3, 1'b0, 16'h0020, 16'h5A5A, 0);
    run_until_idle(50, "glitch");
    glitch = 1'b0;
    step();
    chk("rr_glitch_ack_count", 32'(alog[0].size()), 32'd1);
    chk("fp_glitch_ack_count", 32'(alog[1].size()), 32'd1);
    chk("rr_mem_0020", 32'(mem0[8'h20]), 32'h5A5A);
    chk("fp_mem_0020", 32'(mem1[8'h20]), 32'h5A5A);

    // Randomized traffic on both ports of both instances.
    for (int idx = 0; idx < 4; idx++) begin
      for (int n = 0; n < 30; n++) begin
        push_op(idx, 1'($urandom), 16'($urandom_range(0, 255)), 16'($urandom),
                int'($urandom_range(0, 3)));
      end
    end
    run_until_idle(4000, "random");
    repeat (2) step();

    for (int i = 0; i < 256; i++) begin
      chk($sformatf("rr_mem_%02h", i), 32'(mem0[i]), 32'(sh[0][i]));
      chk($sformatf("fp_mem_%02h", i), 32'(mem1[i]), 32'(sh[1][i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer for the single-port 16-bit main memory.
- Shares the memory between requester 0 (instruction fetch) and requester 1 (load/store unit).
- Accepts one request at a time over a req/ack handshake and drives the memory's address, read_write, enable and bidirectional data bus.
- Returns read data to the granted requester.

Parameters:
- address_size, 16, memory address width; also the width of the m*_addr ports.
- data_width, 16, memory word width; must match the memory's data bus.
- fixed_priority, 0, 0 selects round-robin; 1 means requester 0 always wins a tie.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  requester 0 access request; held until m0_ack.
- m0_rw  in  1  1 = read, 0 = write (same polarity as memory read_write).
- m0_addr  in  address_size  requester 0 word address.
- m0_wdata  in  data_width  requester 0 write data.
- m0_rdata  out  data_width  requester 0 read data; valid with m0_ack on reads.
- m0_ack  out  1  one-cycle completion pulse.
- m1_req, m1_rw, m1_addr, m1_wdata, m1_rdata, m1_ack: same as the m0 set, for requester 1.
- mem_address  out  address_size  to memory address.
- mem_read_write  out  1  to memory read_write.
- mem_enable  out  1  to memory enable.
- mem_data  inout  data_width  to memory data bus.

Behaviour:
- States: IDLE, ISSUE, CAPTURE, RESP. Encoding is one-hot or binary; either is acceptable.
- IDLE: the FSM samples both req lines.
  - If any req is high: latch the winner's addr, rw and wdata plus a grant index, then go to ISSUE.
  - If no req is high: stay in IDLE.
- Tie resolution, round-robin: grant the requester not granted last. The last-grant pointer resets to 1, so m0 wins the first tie.
- Tie resolution, fixed_priority = 1: m0 always wins.
- A lone request is granted immediately.
- ISSUE, one cycle:
  - mem_enable = 1; mem_address and mem_read_write come from the latched values.
  - Write: mem_data is driven with latched wdata; next state RESP.
  - Read: mem_data is hi-Z; next state CAPTURE.
- CAPTURE, one cycle:
  - mem_enable, mem_address and mem_read_write are held as in ISSUE; mem_data stays hi-Z.
  - mem_data is registered into the granted requester's rdata at the closing edge; next state RESP.
- RESP, one cycle:
  - mem_enable = 0; the granted m*_ack = 1.
  - Update the last-grant pointer; next state IDLE.
- Latency from the IDLE cycle that samples req: write ack is visible 2 cycles later, read ack 3 cycles later.
- Throughput: one write per 3 cycles, one read per 4 cycles.
- Handshake rules:
  - req and its fields must be stable from assertion until ack.
  - Changes after the IDLE latch are ignored; the latched transaction always completes.
  - A requester that wants no further access drops req at the edge ending its ack cycle. If req is still high in the next IDLE, it is treated as a new request.
- m*_rdata holds its last captured value until that requester's next read; writes do not alter rdata.
- ack is never asserted for both requesters in the same cycle, and never asserted for the non-granted one.
- Bus discipline:
  - mem_data is driven only during ISSUE of a write; it is hi-Z in every other state and during reset.
  - The memory drives the bus only while enable and read_write are high, so no contention is possible.
- Outside ISSUE/CAPTURE: mem_enable = 0, mem_read_write = 1 (read, safe), mem_address holds its last value.
- Reset values: state IDLE, m0_ack = m1_ack = 0, m0_rdata = m1_rdata = 0, mem_enable = 0, mem_read_write = 1, mem_address = 0, mem_data hi-Z, last-grant = 1, latched fields 0.
- Reset mid-operation: the FSM returns to IDLE at that edge with no ack.
  - A write in ISSUE may already have been sampled by the memory at that same edge. Requesters must reissue after reset.
- The arbiter does not drive the memory's own reset.

Decomposition:
- Package mem_arb_pkg contains:
  - state encoding constants ST_IDLE, ST_ISSUE, ST_CAPTURE, ST_RESP;
  - RW_READ = 1, RW_WRITE = 0;
  - GRANT_M0 = 0, GRANT_M1 = 1.
- Sub-module rr_arbiter2 contains the 2-way combinational picker and the last-grant pointer register, with a pointer-update enable and fixed_priority passthrough.
- Everything else lives in mem_arbiter.

Test Plan:
- Reset held 3 cycles with both req high -> no ack, mem_enable = 0, mem_data hi-Z throughout; after release, m0 is granted first.
- m0 writes 16'hBEEF to 16'h0010, then m0 reads 16'h0010:
  - write -> m0_ack 2 cycles after the sampling IDLE;
  - read -> m0_ack 3 cycles after, with m0_rdata = 16'hBEEF.
- m0 and m1 request continuously (reads of 16'h0001 and 16'h0002, preloaded 16'h1111 and 16'h2222) -> acks alternate m0, m1, m0, m1; each rdata matches its own address; m1_rdata is never disturbed by m0 reads.
- Same stimulus with fixed_priority = 1 -> m0 is acked every transaction and m1 is starved; m1 is acked only after m0 drops req.
- m1 write of 16'h5A5A to 16'h0020 while m0_req toggles mid-transaction -> m1 completes with its latched fields, exactly one m1_ack, memory[16'h0020] = 16'h5A5A.
- Reset asserted during CAPTURE of an m0 read -> no m0_ack, m0_rdata unchanged, FSM in IDLE the next cycle, mem_enable = 0.
